// File: rtl/uart_rx_core.sv
// UART receive core: oversampled start detect, 3-sample majority voting, LSB-first
// deserialization, optional parity and stop check. Define RX_SYNC_EN to add a 2-flop input synchronizer.
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  Par_en,
    input  logic                  Par_type,
    output logic [DATA_WIDTH-1:0] P_Data,
    output logic                  Data_valid,
    output logic                  Par_err,
    output logic                  Stp_err,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0]         LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);

    logic rx;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], RX_IN};
    end

    assign rx = sync_q[1];
`else
    assign rx = RX_IN;
`endif

    state_t                  state;
    logic [PRESCALE_W-1:0]   edge_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [PRESCALE_W-1:0]   p_lat;
    logic                    par_en_lat;
    logic                    par_type_lat;
    logic                    par_fail;
    logic [2:0]              smp;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    pend_valid;
    logic                    pend_par;
    logic                    pend_stp;

    logic [PRESCALE_W-1:0]   mid;
    logic                    sample_now;
    logic                    last_edge;
    logic                    bit_val;
    logic                    exp_par;

    always_comb begin
        mid        = p_lat >> 1;
        sample_now = 1'b0;
        last_edge  = 1'b0;
        if (state != IDLE) begin
            sample_now = (edge_cnt == mid - ONE) || (edge_cnt == mid) || (edge_cnt == mid + ONE);
            last_edge  = (edge_cnt == p_lat - ONE);
        end
        bit_val = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
        exp_par = par_type_lat ? ~^shift_reg : ^shift_reg;
    end

    // Data_valid is a single-cycle strobe with no back-pressure; P_Data holds until the next good frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            p_lat        <= '0;
            par_en_lat   <= 1'b0;
            par_type_lat <= 1'b0;
            par_fail     <= 1'b0;
            smp          <= '0;
            shift_reg    <= '0;
            pend_valid   <= 1'b0;
            pend_par     <= 1'b0;
            pend_stp     <= 1'b0;
            P_Data       <= '0;
            Data_valid   <= 1'b0;
            Par_err      <= 1'b0;
            Stp_err      <= 1'b0;
        end else begin
            // Outputs trail the stop decision by one edge, which lets IDLE catch a back-to-back start.
            Data_valid <= pend_valid;
            Par_err    <= pend_par;
            Stp_err    <= pend_stp;
            if (pend_valid) P_Data <= shift_reg;
            pend_valid <= 1'b0;
            pend_par   <= 1'b0;
            pend_stp   <= 1'b0;

            if (state == IDLE) begin
                if (!rx) begin
                    state        <= START;
                    edge_cnt     <= ONE;
                    bit_cnt      <= '0;
                    p_lat        <= Prescale;
                    par_en_lat   <= Par_en;
                    par_type_lat <= Par_type;
                    par_fail     <= 1'b0;
                end
            end else begin
                if (sample_now) smp <= {smp[1:0], rx};
                if (last_edge) begin
                    edge_cnt <= '0;
                    case (state)
                        START: state <= bit_val ? IDLE : DATA;
                        DATA: begin
                            shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) state <= par_en_lat ? PARITY : STOP;
                        end
                        PARITY: begin
                            if (bit_val != exp_par) par_fail <= 1'b1;
                            state <= STOP;
                        end
                        STOP: begin
                            state      <= IDLE;
                            pend_stp   <= ~bit_val;
                            pend_par   <= par_fail;
                            pend_valid <= bit_val & ~par_fail;
                        end
                        default: state <= IDLE;
                    endcase
                end else begin
                    edge_cnt <= edge_cnt + ONE;
                end
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames, expected pulses queued with their arrival cycle,
// a negedge monitor pops and compares every output pulse.
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int DW = 8;
    localparam int PW = 6;
`ifdef RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          RX_IN;
    logic [PW-1:0] Prescale;
    logic          Par_en;
    logic          Par_type;
    logic [DW-1:0] P_Data;
    logic          Data_valid;
    logic          Par_err;
    logic          Stp_err;
    logic [2:0]    state_dbg;

    uart_rx_core #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .Par_en     (Par_en),
        .Par_type   (Par_type),
        .P_Data     (P_Data),
        .Data_valid (Data_valid),
        .Par_err    (Par_err),
        .Stp_err    (Stp_err),
        .state_dbg  (state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: {arrival cycle[31:0], dv, pe, se, data[7:0]}
    logic [42:0] exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   idle_req = 0;
    int   idle_ack = 0;
    bit   done_req = 1'b0;
    bit   done_ack = 1'b0;
    logic [DW-1:0] last_good = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [42:0] head;
        if (rst) begin
            chk("rst_p_data", 32'(P_Data), 32'd0);
            chk("rst_data_valid", 32'(Data_valid), 32'd0);
            chk("rst_par_err", 32'(Par_err), 32'd0);
            chk("rst_stp_err", 32'(Stp_err), 32'd0);
            chk("rst_state", 32'(state_dbg), 32'd0);
        end else if (Data_valid || Par_err || Stp_err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {21'd0, Data_valid, Par_err, Stp_err, P_Data}, 32'd0);
            end else begin
                head = exp_q.pop_front();
                chk("pulse_flags_data", {21'd0, Data_valid, Par_err, Stp_err, P_Data}, {21'd0, head[10:0]});
                chk("pulse_cycle", 32'(cyc), head[42:11]);
            end
        end else if (exp_q.size() > 0) begin
            head = exp_q[0];
            if (32'(cyc) > head[42:11]) begin
                void'(exp_q.pop_front());
                chk("missing_pulse_cycle", 32'(cyc), head[42:11]);
            end
        end
        if (idle_req != idle_ack) begin
            chk("fsm_idle", 32'(state_dbg), 32'd0);
            idle_ack = idle_req;
        end
        if (done_req && !done_ack) begin
            chk("queue_drained", 32'(exp_q.size()), 32'd0);
            done_ack = 1'b1;
        end
    end

    // driver tasks; each is entered and left 1ns after a rising edge
    task automatic drive_bit(input logic b, input int p, input bit glitch);
        RX_IN = b;
        if (glitch) begin
            repeat (p / 2) @(posedge clk);
            #1 RX_IN = ~b;
            @(posedge clk);
            #1 RX_IN = b;
            repeat (p - p / 2 - 1) @(posedge clk);
            #1;
        end else begin
            repeat (p) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int p, input logic [DW-1:0] d, input bit pen, input bit ptype,
                              input logic pbit, input logic sbit, input int glitch_idx);
        logic dv, pe, se;
        int   n;
        int   t0;
        Prescale = PW'(p);
        Par_en   = pen;
        Par_type = ptype;
        t0 = cyc;
        n  = 10 + (pen ? 1 : 0);
        pe = pen && (pbit != (ptype ? ~^d : ^d));
        se = !sbit;
        dv = !pe && !se;
        if (dv) last_good = d;
        exp_q.push_back({32'(t0 + 1 + n * p + SYNC_LAT), dv, pe, se, last_good});
        drive_bit(1'b0, p, 1'b0);
        // mid-frame config changes must be ignored
        Prescale = (p == 8) ? PW'(16) : PW'(8);
        Par_en   = ~pen;
        Par_type = ~ptype;
        for (int i = 0; i < DW; i++) drive_bit(d[i], p, glitch_idx == i);
        if (pen) drive_bit(pbit, p, 1'b0);
        drive_bit(sbit, p, 1'b0);
        RX_IN = 1'b1;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] partial;
        rst = 1'b1; RX_IN = 1'b1; Prescale = PW'(8); Par_en = 1'b0; Par_type = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        gap(4);

        // 1: P=8, no parity
        send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        gap(6);
        // 2: P=16 even parity, good then bad parity bit
        send_frame(16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        gap(6);
        send_frame(16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        gap(6);
        // 3: P=8 odd parity, stop error alone then both errors
        send_frame(8, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        gap(6);
        send_frame(8, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        gap(6);
        // 4: short low glitch rejected as false start, then a good frame
        Prescale = PW'(16); Par_en = 1'b0;
        RX_IN = 1'b0;
        gap(3);
        RX_IN = 1'b1;
        gap(24);
        idle_req++;
        gap(2);
        send_frame(16, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        gap(6);
        // 5: P=32, one-cycle low at the centre of data bit 3
        send_frame(32, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        gap(6);
        // 6: reset during data bit 4, then a clean frame
        Prescale = PW'(8); Par_en = 1'b0;
        partial = 8'h5A;
        drive_bit(1'b0, 8, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(partial[i], 8, 1'b0);
        RX_IN = partial[4];
        gap(4);
        rst = 1'b1;
        last_good = '0;
        gap(2);
        rst = 1'b0;
        RX_IN = 1'b1;
        gap(20);
        idle_req++;
        gap(2);
        send_frame(8, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        gap(6);
        // back-to-back frames with no idle gap
        send_frame(8, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8, 8'hED, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        gap(20);

        done_req = 1'b1;
        gap(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion earlier", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receive core, the receiving end of the team's UART transmit path (same frame format and parity convention).
Oversamples serial RX_IN, detects the start bit, and deserializes 8 data bits LSB-first. Optionally checks even/odd parity and checks the stop bit.
Delivers the byte on P_Data with a one-cycle Data_valid pulse, or flags Par_err / Stp_err instead.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_W, 6, width of Prescale input

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
RX_IN  input  1  serial line, idle high
Prescale  input  PRESCALE_W  oversampling ratio (clk cycles per bit); legal values 8, 16, 32
Par_en  input  1  1 = frame carries parity bit
Par_type  input  1  0 = even, 1 = odd (same convention as TX)
P_Data  output  DATA_WIDTH  received byte
Data_valid  output  1  one-cycle pulse, P_Data valid
Par_err  output  1  one-cycle pulse, parity mismatch
Stp_err  output  1  one-cycle pulse, stop bit sampled 0

Behaviour:
- Reset (async, rst=1): state IDLE; all counters 0; P_Data=0, Data_valid=0, Par_err=0, Stp_err=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- edge_cnt: 0..P-1 within each bit. bit_cnt: 0..DATA_WIDTH-1 in DATA.
- P (prescale), Par_en and Par_type are latched on start detection. Changes mid-frame have no effect.
- IDLE: when RX_IN=0, go to START with edge_cnt<=1; the detect cycle counts as edge 0.
- Sampling: mid = P>>1. RX_IN is sampled at edge_cnt = mid-1, mid, mid+1. Bit value = majority of the 3 samples. Bit decision is taken at edge_cnt = P-1; then edge_cnt wraps to 0.
- START: if the decided bit is 1 (glitch), go to IDLE with no output pulses. Otherwise go to DATA.
- DATA: shift the decided bit into the shift register LSB-first. After bit_cnt = DATA_WIDTH-1, go to PARITY if Par_en, else STOP.
- PARITY: expected = ^data (even) or ~^data (odd). A mismatch sets an internal par_fail flag.
- STOP: on decision, go to IDLE and register outputs on the following edge:
  - Stp_err = (stop bit == 0)
  - Par_err = par_fail
  - Data_valid = 1 only if neither error; P_Data <= shift register on Data_valid only.
  - On error, P_Data holds its previous value.
- Output timing: pulses occur exactly (1 + DATA_WIDTH + Par_en + 1)*P cycles after the detect cycle. All pulses last 1 cycle. Par_err and Stp_err may assert together.
- Back-to-back frames: IDLE may detect a new start in the same cycle outputs pulse; no dead cycle required.
- Reset mid-frame: immediate return to IDLE; partial byte discarded; no pulses.
- Prescale values other than 8/16/32: behaviour undefined; not verified.

Optional Feature:
- Macro RX_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer (reset value 1) before the FSM. All timings shift by +2 cycles.
- Undefined: RX_IN is used directly; RX_IN is assumed already synchronous to clk.

Test Plan:
1. P=8, Par_en=0, send 0xA5 with stop=1 -> Data_valid pulse 80 cycles after start edge; P_Data=0xA5; Par_err=Stp_err=0.
2. P=16, Par_en=1, Par_type=0, send 0x3C with parity 0 -> Data_valid, P_Data=0x3C. Resend with parity 1 -> Par_err pulse, no Data_valid, P_Data stays 0x3C.
3. P=8, Par_en=1, Par_type=1, send 0x01 with parity 0, stop=0 -> Stp_err pulse only, no Data_valid. Same frame with parity 1, stop=0 -> Par_err and Stp_err together, no Data_valid.
4. P=16, RX_IN low for 3 cycles then high -> no pulses, FSM back in IDLE. A valid 0x55 frame immediately after -> Data_valid, P_Data=0x55.
5. P=32, send 0xFF with a 1-cycle low glitch at mid of bit 3 -> majority rejects glitch, P_Data=0xFF.
6. Assert rst during DATA bit 4 of a frame, release, send 0x81 -> only one Data_valid, P_Data=0x81. Separately, two frames sent back-to-back -> two Data_valid pulses with correct bytes.
